// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, frames 11-bit words,
// strips E0/F0 prefixes and tracks the make code of the held key.
module ps2_keycode_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       keyPress,
    output logic       frameError
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Odd parity holds when the data byte plus its parity bit has an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic [1:0]        clk_sync_r;
    logic [1:0]        data_sync_r;
    logic              filt_level_r;
    logic [FILT_W-1:0] filt_cnt_r;
    logic              fe_r;

    state_t            state_r, state_s;
    logic [3:0]        bit_cnt_r, bit_cnt_s;
    logic [8:0]        shift_r, shift_s;
    logic              stop_r, stop_s;
    logic              ext_r, ext_s;
    logic              brk_r, brk_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
    logic [7:0]        key_code_r, key_code_s;
    logic              key_press_r, key_press_s;
    logic              frame_error_r, frame_error_s;
    logic              frame_ok_s;

    assign keyCode    = key_code_r;
    assign keyPress   = key_press_r;
    assign frameError = frame_error_r;

    // Two-stage synchronizers for the asynchronous PS/2 pins (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter on the clock: the level flips only after FILTER_LEN
    // consecutive differing samples; a 1->0 flip raises the fe strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_level_r <= 1'b1;
            filt_cnt_r   <= '0;
            fe_r         <= 1'b0;
        end else if (clk_sync_r[1] != filt_level_r) begin
            if (filt_cnt_r == FILT_W'(FILTER_LEN - 1)) begin
                filt_level_r <= clk_sync_r[1];
                filt_cnt_r   <= '0;
                fe_r         <= filt_level_r;
            end else begin
                filt_cnt_r   <= filt_cnt_r + FILT_W'(1);
                fe_r         <= 1'b0;
            end
        end else begin
            filt_cnt_r <= '0;
            fe_r       <= 1'b0;
        end
    end

    // Frame FSM state and datapath registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 4'd0;
            shift_r       <= 9'd0;
            stop_r        <= 1'b0;
            ext_r         <= 1'b0;
            brk_r         <= 1'b0;
            to_cnt_r      <= '0;
            key_code_r    <= 8'h00;
            key_press_r   <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            shift_r       <= shift_s;
            stop_r        <= stop_s;
            ext_r         <= ext_s;
            brk_r         <= brk_s;
            to_cnt_r      <= to_cnt_s;
            key_code_r    <= key_code_s;
            key_press_r   <= key_press_s;
            frame_error_r <= frame_error_s;
        end
    end

    assign frame_ok_s = odd_parity_ok(shift_r) && stop_r;

    // Next-state logic: bit collection, timeout abort and byte interpretation.
    // shift_r collects d0..d7 then parity, so after nine shifts d0 sits at bit 0.
    always_comb begin
        state_s       = state_r;
        bit_cnt_s     = bit_cnt_r;
        shift_s       = shift_r;
        stop_s        = stop_r;
        ext_s         = ext_r;
        brk_s         = brk_r;
        to_cnt_s      = to_cnt_r;
        key_code_s    = key_code_r;
        key_press_s   = 1'b0;
        frame_error_s = 1'b0;

        case (state_r)
            IDLE: begin
                to_cnt_s = '0;
                if (fe_r && !data_sync_r[1]) begin
                    state_s   = RECV;
                    bit_cnt_s = 4'd1;
                end else begin
                    state_s   = IDLE;
                end
            end

            RECV: begin
                if (fe_r) begin
                    to_cnt_s = '0;
                    if (bit_cnt_r == 4'd10) begin
                        stop_s  = data_sync_r[1];
                        state_s = CHECK;
                    end else begin
                        shift_s   = {data_sync_r[1], shift_r[8:1]};
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_error_s = 1'b1;
                    state_s       = IDLE;
                    bit_cnt_s     = 4'd0;
                    to_cnt_s      = '0;
                    ext_s         = 1'b0;
                    brk_s         = 1'b0;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end

            CHECK: begin
                state_s   = IDLE;
                bit_cnt_s = 4'd0;
                if (!frame_ok_s) begin
                    frame_error_s = 1'b1;
                    ext_s         = 1'b0;
                    brk_s         = 1'b0;
                end else if (shift_r[7:0] == 8'hE0) begin
                    ext_s = 1'b1;
                end else if (shift_r[7:0] == 8'hF0) begin
                    brk_s = 1'b1;
                end else if (brk_r) begin
                    // A break only clears the code if it names the held key.
                    if (shift_r[7:0] == key_code_r) begin
                        key_code_s = 8'h00;
                    end else begin
                        key_code_s = key_code_r;
                    end
                    ext_s = 1'b0;
                    brk_s = 1'b0;
                end else begin
                    key_code_s  = shift_r[7:0];
                    key_press_s = 1'b1;
                    ext_s       = 1'b0;
                end
            end

            default: begin
                state_s   = IDLE;
                bit_cnt_s = 4'd0;
                ext_s     = 1'b0;
                brk_s     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Self-checking bench for ps2_keycode_decoder: byte-level keyboard model,
// per-cycle output compare, and directed PS/2 frames.
module tb_ps2_keycode_decoder;

    localparam int HALF   = 40;   // clk cycles per PS/2 clock half period
    localparam int SETTLE = 30;   // cycles after a frame before expectations apply

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyCode;
    logic       keyPress;
    logic       frameError;

    int n_tests = 0;
    int n_fail  = 0;
    int kp_seen = 0;
    int fe_seen = 0;
    logic kp_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic settled = 1'b0;

    // Keyboard-level model state
    logic [7:0] m_key = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    ps2_keycode_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keyCode    (keyCode),
        .keyPress   (keyPress),
        .frameError (frameError)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-level rules of the keyboard protocol.
    task automatic model_byte(input logic [7:0] b, input logic ok,
                              output int ekp, output int efe);
        ekp = 0;
        efe = 0;
        if (!ok) begin
            efe   = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            if (b == m_key) m_key = 8'h00;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_key = b;
            ekp   = 1;
            m_ext = 1'b0;
        end
    endtask

    // Per-cycle compare: pulse shape, pulse counting and held key code.
    always @(negedge clk) begin
        if (!reset) begin
            check("pulse_overlap", int'(keyPress & frameError), 0);
            check("keyPress_width", int'(keyPress & kp_prev), 0);
            check("frameError_width", int'(frameError & fe_prev), 0);
            if (keyPress) kp_seen++;
            if (frameError) fe_seen++;
            if (settled) check("keyCode_track", int'(keyCode), int'(m_key));
        end
        kp_prev = keyPress;
        fe_prev = frameError;
    end

    task automatic drive_bit(input logic d);
        @(negedge clk);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int   kp0;
        int   fe0;
        int   ekp;
        int   efe;
        logic par;
        kp0 = kp_seen;
        fe0 = fe_seen;
        par = (~^b) ^ bad_par;
        settled = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (SETTLE) @(negedge clk);
        model_byte(b, !bad_par && !bad_stop, ekp, efe);
        settled = 1'b1;
        check($sformatf("keyPress_count_%02h", b), kp_seen - kp0, ekp);
        check($sformatf("frameError_count_%02h", b), fe_seen - fe0, efe);
    endtask

    initial begin
        int kp_base;
        int fe_base;

        // Reset state
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_keyCode", int'(keyCode), 8'h00);
        check("reset_keyPress", int'(keyPress), 0);
        check("reset_frameError", int'(frameError), 0);
        settled = 1'b1;

        // Make, then break of the same key
        kp_base = kp_seen;
        send_frame(8'h1D, 1'b0, 1'b0);
        check("make_1D", int'(keyCode), 8'h1D);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("break_1D", int'(keyCode), 8'h00);
        check("one_press_1D_seq", kp_seen - kp_base, 1);

        // Extended key: prefix stripped, break clears
        kp_base = kp_seen;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_make_75", int'(keyCode), 8'h75);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_break_75", int'(keyCode), 8'h00);
        check("one_press_75_seq", kp_seen - kp_base, 1);

        // Parity error leaves held key untouched
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b1, 1'b0);
        check("parity_err_keeps", int'(keyCode), 8'h1D);

        // Typematic repeat, key replacement, stale break ignored
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("stale_break_ignored", int'(keyCode), 8'h1C);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("break_1C", int'(keyCode), 8'h00);

        // Stop bit error
        send_frame(8'h22, 1'b0, 1'b1);

        // Falling edge with data high while idle is not a start bit
        fe_base = fe_seen;
        kp_base = kp_seen;
        drive_bit(1'b1);
        repeat (SETTLE) @(negedge clk);
        check("idle_high_no_err", fe_seen - fe_base, 0);
        check("idle_high_no_press", kp_seen - kp_base, 0);

        // Truncated frame: start + 4 data bits, then the clock stays high
        fe_base = fe_seen;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        ps2_data = 1'b1;
        repeat (9800) @(negedge clk);
        check("timeout_not_early", fe_seen - fe_base, 0);
        repeat (400) @(negedge clk);
        check("timeout_fired", fe_seen - fe_base, 1);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(8'h1B, 1'b0, 1'b0);
        check("after_timeout_1B", int'(keyCode), 8'h1B);

        // Reset after 6 bits of an F0 frame; the remaining bits are all ones
        settled = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_keyCode", int'(keyCode), 8'h00);
        check("midreset_keyPress", int'(keyPress), 0);
        check("midreset_frameError", int'(frameError), 0);
        m_key = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
        reset = 1'b0;
        settled = 1'b1;
        fe_base = fe_seen;
        kp_base = kp_seen;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (SETTLE) @(negedge clk);
        check("post_reset_no_err", fe_seen - fe_base, 0);
        check("post_reset_no_press", kp_seen - kp_base, 0);

        // Two-cycle clock glitch with data low must not start a frame
        fe_base = fe_seen;
        kp_base = kp_seen;
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_no_err", fe_seen - fe_base, 0);
        check("glitch_no_press", kp_seen - kp_base, 0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("after_glitch_1D", int'(keyCode), 8'h1D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
